// File: rtl/atm_keypad_frontend.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : atm_keypad_frontend
// Brief   : Card/keypad front end producing ATM controller commands over a
//           valid/ready handshake. Optional inactivity timeout: INACTIVITY_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module atm_keypad_frontend #(
  parameter int MAX_PIN_TRIES = 3
`ifdef INACTIVITY_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       card_in,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       pin_ok,
  input  logic       pin_bad,
  output logic       ic,
  output logic       lc,
  output logic       ex,
  output logic       go_main,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_kind,
  output logic [1:0] cmd_op,
  output logic [3:0] cmd_pin,
  output logic [5:0] cmd_amount,
  output logic       key_err
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LANG     = 4'd1,
    S_PIN      = 4'd2,
    S_PIN_WAIT = 4'd3,
    S_MENU     = 4'd4,
    S_AMOUNT   = 4'd5,
    S_CMD      = 4'd6,
    S_EXIT     = 4'd7,
    S_EJECT    = 4'd8
  } state_t;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;
  localparam logic [1:0] KIND_PIN   = 2'b00;
  localparam logic [1:0] KIND_OP    = 2'b01;
  localparam logic [1:0] KIND_AMT   = 2'b10;
  localparam logic [1:0] OP_BALANCE = 2'b10;
  localparam logic [2:0] MAX_TRIES  = 3'(MAX_PIN_TRIES);

  state_t      state_q, state_d, ret_q, ret_d;
  logic [6:0]  acc_q, acc_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic [2:0]  try_q, try_d;
  logic        op_dep_q, op_dep_d;
  logic        pend_q, pend_d;
  logic        card_q, card_d;
  logic        ic_q, ic_d, lc_q, lc_d, ex_q, ex_d, go_main_q, go_main_d, key_err_q, key_err_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [1:0]  cmd_kind_q, cmd_kind_d, cmd_op_q, cmd_op_d;
  logic [3:0]  cmd_pin_q, cmd_pin_d;
  logic [5:0]  cmd_amount_q, cmd_amount_d;

  logic        card_rise, card_fall;
  logic        k_digit, k_enter, k_clear, k_cancel;
  logic [9:0]  acc_ext, amt_lim;

`ifdef INACTIVITY_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_counting;
`endif

  assign card_rise = card_in & ~card_q;
  assign card_fall = ~card_in & card_q;
  assign k_digit   = key_valid && (key_code <= 4'd9);
  assign k_enter   = key_valid && (key_code == KEY_ENTER);
  assign k_clear   = key_valid && (key_code == KEY_CLEAR);
  assign k_cancel  = key_valid && (key_code == KEY_CANCEL);
  // Widened so the range check happens before the 7-bit write-back
  assign acc_ext   = ({3'b000, acc_q} * 10'd10) + {6'b000000, key_code};
  assign amt_lim   = op_dep_q ? 10'd31 : 10'd63;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    acc_d        = acc_q;
    dcnt_d       = dcnt_q;
    try_d        = try_q;
    op_dep_d     = op_dep_q;
    pend_d       = pend_q;
    card_d       = card_in;
    ic_d         = 1'b0;
    lc_d         = 1'b0;
    go_main_d    = 1'b0;
    key_err_d    = 1'b0;
    cmd_valid_d  = cmd_valid_q;
    cmd_kind_d   = cmd_kind_q;
    cmd_op_d     = cmd_op_q;
    cmd_pin_d    = cmd_pin_q;
    cmd_amount_d = cmd_amount_q;

    if (card_fall && state_q != S_IDLE && state_q != S_EJECT && state_q != S_EXIT) begin
      state_d     = S_EXIT;
      cmd_valid_d = 1'b0;
      pend_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (card_rise) begin
            ic_d    = 1'b1;
            state_d = S_LANG;
          end
        end
        S_LANG: begin
          if (k_enter) begin
            lc_d    = 1'b1;
            state_d = S_PIN;
            acc_d   = '0;
            dcnt_d  = '0;
          end else if (k_digit) begin
            key_err_d = 1'b1;
          end else if (k_clear) begin
            acc_d  = '0;
            dcnt_d = '0;
          end else if (k_cancel) begin
            state_d = S_EXIT;
          end
        end
        S_PIN: begin
          if (k_digit) begin
            if (acc_ext <= 10'd15) begin
              acc_d  = acc_ext[6:0];
              dcnt_d = (dcnt_q == 3'd7) ? dcnt_q : dcnt_q + 3'd1;
            end else begin
              key_err_d = 1'b1;
            end
          end else if (k_enter) begin
            if (dcnt_q != 3'd0) begin
              state_d     = S_CMD;
              ret_d       = S_PIN_WAIT;
              cmd_valid_d = 1'b1;
              cmd_kind_d  = KIND_PIN;
              cmd_pin_d   = acc_q[3:0];
              acc_d       = '0;
              dcnt_d      = '0;
            end else begin
              key_err_d = 1'b1;
            end
          end else if (k_clear) begin
            acc_d  = '0;
            dcnt_d = '0;
          end else if (k_cancel) begin
            state_d = S_EXIT;
          end
        end
        S_PIN_WAIT: begin
          if (pin_bad) begin
            if ((try_q + 3'd1) >= MAX_TRIES) begin
              state_d = S_EXIT;
            end else begin
              try_d   = try_q + 3'd1;
              state_d = S_PIN;
              acc_d   = '0;
              dcnt_d  = '0;
            end
          end else if (pin_ok) begin
            try_d   = '0;
            state_d = S_MENU;
          end
        end
        S_MENU: begin
          if (k_digit) begin
            case (key_code)
              4'd0, 4'd1: begin
                op_dep_d = key_code[0];
                state_d  = S_AMOUNT;
                acc_d    = '0;
                dcnt_d   = '0;
              end
              4'd2: begin
                state_d     = S_CMD;
                ret_d       = S_MENU;
                cmd_valid_d = 1'b1;
                cmd_kind_d  = KIND_OP;
                cmd_op_d    = OP_BALANCE;
              end
              4'd3:    state_d   = S_EXIT;
              default: key_err_d = 1'b1;
            endcase
          end else if (k_clear) begin
            acc_d  = '0;
            dcnt_d = '0;
          end else if (k_cancel) begin
            state_d = S_EXIT;
          end
        end
        S_AMOUNT: begin
          if (k_digit) begin
            if (acc_ext <= amt_lim) begin
              acc_d  = acc_ext[6:0];
              dcnt_d = (dcnt_q == 3'd7) ? dcnt_q : dcnt_q + 3'd1;
            end else begin
              key_err_d = 1'b1;
            end
          end else if (k_enter) begin
            if (acc_q != 7'd0) begin
              // Operation goes first; amount is staged now and follows on the next transfer
              state_d      = S_CMD;
              ret_d        = S_MENU;
              pend_d       = 1'b1;
              cmd_valid_d  = 1'b1;
              cmd_kind_d   = KIND_OP;
              cmd_op_d     = {1'b0, op_dep_q};
              cmd_amount_d = acc_q[5:0];
              acc_d        = '0;
              dcnt_d       = '0;
            end else begin
              key_err_d = 1'b1;
            end
          end else if (k_clear) begin
            acc_d  = '0;
            dcnt_d = '0;
          end else if (k_cancel) begin
            go_main_d = 1'b1;
            state_d   = S_MENU;
            acc_d     = '0;
            dcnt_d    = '0;
          end
        end
        S_CMD: begin
          if (cmd_ready) begin
            if (pend_q) begin
              pend_d     = 1'b0;
              cmd_kind_d = KIND_AMT;
            end else begin
              cmd_valid_d = 1'b0;
              state_d     = ret_q;
            end
          end
        end
        S_EXIT: begin
          state_d = S_EJECT;
          acc_d   = '0;
          dcnt_d  = '0;
          try_d   = '0;
        end
        S_EJECT: begin
          if (!card_in) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef INACTIVITY_TIMEOUT_EN
    tmo_counting = (state_q == S_LANG) || (state_q == S_PIN) ||
                   (state_q == S_MENU) || (state_q == S_AMOUNT);
    if (tmo_counting && !key_valid && !card_fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_EXIT;
    end
    if (key_valid || state_d != state_q) tmo_d = '0;
    else if (tmo_counting)               tmo_d = tmo_q + 1'b1;
    else                                 tmo_d = tmo_q;
`endif

    ex_d = (state_d == S_EXIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      acc_q        <= '0;
      dcnt_q       <= '0;
      try_q        <= '0;
      op_dep_q     <= 1'b0;
      pend_q       <= 1'b0;
      card_q       <= 1'b0;
      ic_q         <= 1'b0;
      lc_q         <= 1'b0;
      ex_q         <= 1'b0;
      go_main_q    <= 1'b0;
      key_err_q    <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_kind_q   <= '0;
      cmd_op_q     <= '0;
      cmd_pin_q    <= '0;
      cmd_amount_q <= '0;
`ifdef INACTIVITY_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      acc_q        <= acc_d;
      dcnt_q       <= dcnt_d;
      try_q        <= try_d;
      op_dep_q     <= op_dep_d;
      pend_q       <= pend_d;
      card_q       <= card_d;
      ic_q         <= ic_d;
      lc_q         <= lc_d;
      ex_q         <= ex_d;
      go_main_q    <= go_main_d;
      key_err_q    <= key_err_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_kind_q   <= cmd_kind_d;
      cmd_op_q     <= cmd_op_d;
      cmd_pin_q    <= cmd_pin_d;
      cmd_amount_q <= cmd_amount_d;
`ifdef INACTIVITY_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign ic         = ic_q;
  assign lc         = lc_q;
  assign ex         = ex_q;
  assign go_main    = go_main_q;
  assign key_err    = key_err_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_kind   = cmd_kind_q;
  assign cmd_op     = cmd_op_q;
  assign cmd_pin    = cmd_pin_q;
  assign cmd_amount = cmd_amount_q;

endmodule
`default_nettype wire

// File: tb/tb_atm_keypad_frontend.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_atm_keypad_frontend
// Brief   : Directed, table-driven bench for atm_keypad_frontend.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_atm_keypad_frontend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       card_in = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       pin_ok = 1'b0;
  logic       pin_bad = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       ic, lc, ex, go_main, cmd_valid, key_err;
  logic [1:0] cmd_kind, cmd_op;
  logic [3:0] cmd_pin;
  logic [5:0] cmd_amount;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef INACTIVITY_TIMEOUT_EN
  atm_keypad_frontend #(.MAX_PIN_TRIES(3), .TIMEOUT_CYCLES(16)) dut (
`else
  atm_keypad_frontend #(.MAX_PIN_TRIES(3)) dut (
`endif
    .clk(clk), .rst(rst), .card_in(card_in), .key_valid(key_valid), .key_code(key_code),
    .pin_ok(pin_ok), .pin_bad(pin_bad), .ic(ic), .lc(lc), .ex(ex), .go_main(go_main),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_op(cmd_op),
    .cmd_pin(cmd_pin), .cmd_amount(cmd_amount), .key_err(key_err)
  );

  // pls = {ic, lc, ex, go_main, key_err, cmd_valid}
  localparam logic [5:0] P0 = 6'b000000;
  localparam logic [5:0] IC = 6'b100000;
  localparam logic [5:0] LC = 6'b010000;
  localparam logic [5:0] EX = 6'b001000;
  localparam logic [5:0] GM = 6'b000100;
  localparam logic [5:0] KE = 6'b000010;
  localparam logic [5:0] V  = 6'b000001;
  localparam logic [3:0] ENT = 4'hA;
  localparam logic [3:0] CLR = 4'hB;
  localparam logic [3:0] CAN = 4'hC;

  typedef struct {
    logic       card;
    logic       kv;
    logic [3:0] kc;
    logic       rdy;
    logic       ok;
    logic       bad;
    logic [5:0] pls;
    logic [1:0] kind;
    logic [1:0] op;
    logic [3:0] pin;
    logic [5:0] amt;
  } vec_t;

  vec_t vq[$];

  function automatic logic [19:0] outs();
    return {ic, lc, ex, go_main, key_err, cmd_valid, cmd_kind, cmd_op, cmd_pin, cmd_amount};
  endfunction

  task automatic add(input logic c, input logic kv, input logic [3:0] kc, input logic rdy,
                     input logic ok, input logic bad, input logic [5:0] pls,
                     input logic [1:0] kind, input logic [1:0] op, input logic [3:0] pin,
                     input logic [5:0] amt);
    vq.push_back('{c, kv, kc, rdy, ok, bad, pls, kind, op, pin, amt});
  endtask

  task automatic step(input logic c, input logic kv, input logic [3:0] kc, input logic rdy,
                      input logic ok, input logic bad);
    card_in = c; key_valid = kv; key_code = kc; cmd_ready = rdy; pin_ok = ok; pin_bad = bad;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    // Main session: login, withdraw with held-off ready, balance, deposit corner cases, card pull
    add(1,0,0,  0,0,0, IC, 0,0, 0,0);
    add(1,1,ENT,0,0,0, LC, 0,0, 0,0);
    add(1,1,1,  0,0,0, P0, 0,0, 0,0);
    add(1,1,3,  0,0,0, P0, 0,0, 0,0);
    add(1,1,ENT,1,0,0, V,  0,0,13,0);
    add(1,0,0,  1,0,0, P0, 0,0,13,0);
    add(1,0,0,  0,1,0, P0, 0,0,13,0);
    add(1,1,0,  0,0,0, P0, 0,0,13,0);
    add(1,1,6,  0,0,0, P0, 0,0,13,0);
    add(1,1,4,  0,0,0, KE, 0,0,13,0);
    add(1,1,ENT,0,0,0, V,  1,0,13,6);
    add(1,0,0,  0,0,0, V,  1,0,13,6);
    add(1,1,5,  0,0,0, V,  1,0,13,6);
    add(1,0,0,  0,0,0, V,  1,0,13,6);
    add(1,0,0,  0,0,0, V,  1,0,13,6);
    add(1,0,0,  0,0,0, V,  1,0,13,6);
    add(1,0,0,  1,0,0, V,  2,0,13,6);
    add(1,0,0,  1,0,0, P0, 2,0,13,6);
    add(1,1,2,  0,0,0, V,  1,2,13,6);
    add(1,0,0,  1,0,0, P0, 1,2,13,6);
    add(1,1,1,  0,0,0, P0, 1,2,13,6);
    add(1,1,3,  0,0,0, P0, 1,2,13,6);
    add(1,1,2,  0,0,0, KE, 1,2,13,6);
    add(1,1,CAN,0,0,0, GM, 1,2,13,6);
    add(1,1,7,  0,0,0, KE, 1,2,13,6);
    add(1,1,1,  0,0,0, P0, 1,2,13,6);
    add(1,1,ENT,0,0,0, KE, 1,2,13,6);
    add(1,1,5,  0,0,0, P0, 1,2,13,6);
    add(1,1,CLR,0,0,0, P0, 1,2,13,6);
    add(1,1,ENT,0,0,0, KE, 1,2,13,6);
    add(1,1,9,  0,0,0, P0, 1,2,13,6);
    add(0,1,ENT,1,0,0, EX, 1,2,13,6);
    add(0,0,0,  0,0,0, P0, 1,2,13,6);
    add(0,0,0,  0,0,0, P0, 1,2,13,6);
    // Second session: LANG/PIN key errors, three rejected PINs, eject
    add(1,0,0,  0,0,0, IC, 1,2,13,6);
    add(1,1,5,  0,0,0, KE, 1,2,13,6);
    add(1,1,ENT,0,0,0, LC, 1,2,13,6);
    add(1,1,ENT,0,0,0, KE, 1,2,13,6);
    add(1,1,2,  0,0,0, P0, 1,2,13,6);
    add(1,1,0,  0,0,0, KE, 1,2,13,6);
    add(1,1,ENT,1,0,0, V,  0,2, 2,6);
    add(1,0,0,  1,0,0, P0, 0,2, 2,6);
    add(1,0,0,  0,0,1, P0, 0,2, 2,6);
    add(1,1,0,  0,0,0, P0, 0,2, 2,6);
    add(1,1,ENT,1,0,0, V,  0,2, 0,6);
    add(1,0,0,  1,0,0, P0, 0,2, 0,6);
    add(1,0,0,  0,1,1, P0, 0,2, 0,6);
    add(1,1,7,  0,0,0, P0, 0,2, 0,6);
    add(1,1,ENT,1,0,0, V,  0,2, 7,6);
    add(1,0,0,  1,0,0, P0, 0,2, 7,6);
    add(1,0,0,  0,0,1, EX, 0,2, 7,6);
    add(1,0,0,  0,0,0, P0, 0,2, 7,6);
    add(1,1,ENT,0,0,0, P0, 0,2, 7,6);
    add(0,0,0,  0,0,0, P0, 0,2, 7,6);
    add(0,1,ENT,0,0,0, P0, 0,2, 7,6);

    rst = 1'b1;
    repeat (2) step(0,0,0,0,0,0);
    chk("reset_state", {12'd0, outs()}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].card, vq[i].kv, vq[i].kc, vq[i].rdy, vq[i].ok, vq[i].bad);
      chk($sformatf("vec%0d", i), {12'd0, outs()},
          {12'd0, vq[i].pls, vq[i].kind, vq[i].op, vq[i].pin, vq[i].amt});
    end

    // Reset while a command is pending drops cmd_valid and clears all fields
    step(1,0,0,0,0,0);   chk("s3_ic", {31'd0, ic}, 32'd1);
    step(1,1,ENT,0,0,0); chk("s3_lc", {31'd0, lc}, 32'd1);
    step(1,1,4,0,0,0);
    step(1,1,ENT,0,0,0); chk("s3_cmd", {27'd0, cmd_valid, cmd_pin}, {27'd0, 1'b1, 4'd4});
    rst = 1'b1;
    step(1,0,0,1,0,0);   chk("s3_rst_mid_cmd", {12'd0, outs()}, 32'd0);
    rst = 1'b0;

    // Log in again and sit idle in MENU
    step(1,0,0,0,0,0);   chk("s4_ic", {31'd0, ic}, 32'd1);
    step(1,1,ENT,0,0,0);
    step(1,1,1,0,0,0);
    step(1,1,ENT,1,0,0); chk("s4_cmd", {27'd0, cmd_valid, cmd_pin}, {27'd0, 1'b1, 4'd1});
    step(1,0,0,1,0,0);
    step(1,0,0,0,1,0);
    for (int i = 1; i <= 20; i++) begin
      step(1,0,0,0,0,0);
`ifdef INACTIVITY_TIMEOUT_EN
      chk($sformatf("idle_ex_c%0d", i), {31'd0, ex}, {31'd0, (i == 16)});
`else
      chk($sformatf("idle_ex_c%0d", i), {31'd0, ex}, 32'd0);
`endif
    end
`ifndef INACTIVITY_TIMEOUT_EN
    step(1,1,CAN,0,0,0); chk("menu_cancel_ex", {31'd0, ex}, 32'd1);
    step(1,0,0,0,0,0);   chk("menu_cancel_ex_end", {31'd0, ex}, 32'd0);
`endif
    step(0,0,0,0,0,0);
    step(0,0,0,0,0,0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
